axi4_lite_rd_fifo_ctrl: RTL and testbench
=========================================

Name: axi4_lite_rd_fifo_ctrl

Overview:
Control sequencer for the AXI4-Lite read FIFO pair (AR FIFO and R FIFO). Accepts upstream AR handshakes into the AR FIFO and issues AR beats downstream from it. Downstream issue is credit-gated, so the R FIFO can never overflow. Pops responses back to the upstream master and supports a graceful flush/drain. The block handles control only: payloads (araddr, rdata, rresp) flow through the FIFOs untouched.

Parameters:
MAX_OUT, 4, maximum outstanding reads; must be <= R FIFO depth; legal range 1..255
CW, $clog2(MAX_OUT+1), width of the outstanding counter (derived; do not override)
TIMEOUT, 1024, watchdog cycle limit (optional feature only); legal range 2..2^20

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
s_arvalid  in  1  upstream AR valid
s_arready  out  1  upstream AR ready
ar_wr_en  out  1  AR FIFO push
ar_wr_full  in  1  AR FIFO full
ar_rd_en  out  1  AR FIFO pop; the FIFO is first-word-fall-through
ar_rd_empty  in  1  AR FIFO empty
m_arvalid  out  1  downstream AR valid
m_arready  in  1  downstream AR ready
m_rvalid  in  1  downstream R valid
m_rready  out  1  downstream R ready
r_wr_en  out  1  R FIFO push
r_wr_full  in  1  R FIFO full
r_rd_en  out  1  R FIFO pop; the FIFO is first-word-fall-through
r_rd_empty  in  1  R FIFO empty
s_rvalid  out  1  upstream R valid
s_rready  in  1  upstream R ready
flush_req  in  1  level request: stop issuing and drain
flush_done  out  1  drained: no issued read without a returned response
outstanding  out  CW  current count of in-flight reads
timeout_err  out  1  sticky watchdog flag (optional feature only)

Behaviour:
- Reset (aresetn low, asynchronous): state=RUN, outstanding=0, ar_pend=0, flush_done=0, timeout_err=0, m_arvalid=0.
- Upstream AR path (combinational):
  - s_arready = !ar_wr_full && state!=FLUSHED.
  - ar_wr_en = s_arvalid && s_arready.
- Credit: credit_ok = (outstanding < MAX_OUT).
- Downstream AR path:
  - ar_pend is a register; m_arvalid = ar_pend || issue_ok.
  - issue_ok = state==RUN && !ar_rd_empty && credit_ok.
  - ar_rd_en = m_arvalid && m_arready (single-cycle pop on handshake).
  - When m_arvalid=1 && !m_arready, ar_pend is set the next cycle. m_arvalid then stays high until accepted, regardless of flush_req or credit (AXI stability rule).
  - ar_pend clears on handshake. Back-to-back issue is allowed: one AR per cycle.
- Downstream R path:
  - m_rready = !r_wr_full.
  - r_wr_en = m_rvalid && m_rready.
- Upstream R path:
  - s_rvalid = !r_rd_empty.
  - r_rd_en = s_rvalid && s_rready.
- Outstanding counter:
  - +1 on AR handshake; -1 on r_rd_en; unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUT. Underflow (r_rd_en at 0) is a protocol error: the bench asserts it; RTL saturates at 0.
- State machine:
  - RUN: on flush_req=1, go to DRAIN. A beat already presented (ar_pend or m_arvalid high) completes and counts.
  - DRAIN: no new issue. When outstanding==0 && !ar_pend, go to FLUSHED.
  - FLUSHED: flush_done=1; s_arready=0. On flush_req=0, go to RUN next cycle and flush_done=0.
  - flush_req deasserted during DRAIN: return to RUN.
- The AR FIFO contents are not discarded by a flush; they resume on return to RUN.
- Reset mid-operation: all state clears immediately. The FIFOs are reset by the same aresetn outside this block.

Optional Feature:
Macro AXI4_LITE_RD_FIFO_CTRL_TIMEOUT_EN.
- When defined: a watchdog counter increments each cycle while outstanding>0 and no r_wr_en occurs, and resets to 0 on r_wr_en or when outstanding==0. When it reaches TIMEOUT, timeout_err sets and remains set until reset.
- When undefined: counter logic is absent and timeout_err is tied 0.

Test Plan:
- Single read: 1 s_arvalid beat, m_arready=1, m_rvalid after 3 cycles, s_rready=1 -> m_arvalid one cycle; outstanding goes 0→1→0; s_rvalid one cycle.
- Credit stall: MAX_OUT=4, 6 ARs queued, m_rvalid held 0 -> exactly 4 downstream handshakes; m_arvalid=0 while outstanding=4. Release one R pop -> 5th AR issues the next cycle.
- AXI stability: m_arready=0 with m_arvalid=1, then flush_req=1 -> m_arvalid stays 1 until m_arready=1. Then DRAIN, and flush_done=1 once outstanding=0.
- Simultaneous inc/dec: outstanding=2, AR handshake and r_rd_en in the same cycle -> outstanding stays 2.
- Backpressure: r_wr_full=1 -> m_rready=0 and r_wr_en=0. Full clears -> response accepted next cycle.
- Timeout (macro on, TIMEOUT=16): 1 read issued, no R -> timeout_err=1 exactly 16 cycles after the handshake; stays 1 after the R arrives.

Source files
------------

// File: rtl/axi4_lite_rd_fifo_ctrl_if.sv
// Handshake bundle between the read FIFO control sequencer and its
// surroundings: upstream AXI4-Lite AR/R, downstream AXI4-Lite AR/R and the
// push/pop/status strobes of the AR and R FIFOs.
// The master modport is the sequencer's view; slave is the environment's view.
interface axi4_lite_rd_fifo_ctrl_if;
  logic s_arvalid;
  logic s_arready;
  logic ar_wr_en;
  logic ar_wr_full;
  logic ar_rd_en;
  logic ar_rd_empty;
  logic m_arvalid;
  logic m_arready;
  logic m_rvalid;
  logic m_rready;
  logic r_wr_en;
  logic r_wr_full;
  logic r_rd_en;
  logic r_rd_empty;
  logic s_rvalid;
  logic s_rready;

  modport master (
    input  s_arvalid,
    output s_arready,
    output ar_wr_en,
    input  ar_wr_full,
    output ar_rd_en,
    input  ar_rd_empty,
    output m_arvalid,
    input  m_arready,
    input  m_rvalid,
    output m_rready,
    output r_wr_en,
    input  r_wr_full,
    output r_rd_en,
    input  r_rd_empty,
    output s_rvalid,
    input  s_rready
  );

  modport slave (
    output s_arvalid,
    input  s_arready,
    input  ar_wr_en,
    output ar_wr_full,
    input  ar_rd_en,
    output ar_rd_empty,
    input  m_arvalid,
    output m_arready,
    output m_rvalid,
    input  m_rready,
    input  r_wr_en,
    output r_wr_full,
    input  r_rd_en,
    output r_rd_empty,
    input  s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/axi4_lite_rd_fifo_ctrl.sv
// Control sequencer for the AXI4-Lite read FIFO pair (AR FIFO and R FIFO).
// Upstream ARs are pushed into the AR FIFO; downstream ARs are issued from
// the first-word-fall-through AR FIFO only while a response credit exists,
// so the R FIFO can never overflow. Responses are popped back upstream.
// A level flush request stops new issue, lets in-flight reads return and
// then reports flush_done; the AR FIFO contents survive the flush.
// Payloads never pass through this block.
//
// Optional watchdog: define AXI4_LITE_RD_FIFO_CTRL_TIMEOUT_EN to enable the
// sticky timeout_err flag; otherwise timeout_err is tied low.
module axi4_lite_rd_fifo_ctrl #(
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1),
  parameter int TIMEOUT = 1024
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  axi4_lite_rd_fifo_ctrl_if.master      bus,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic [CW-1:0]                 outstanding,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  state_t state;
  logic   ar_pend;
  logic   credit_ok;
  logic   issue_ok;
  logic   ar_hs;
  logic   r_pop;

  // Upstream AR acceptance is refused only by a full AR FIFO or a completed flush.
  assign bus.s_arready = !bus.ar_wr_full && (state != FLUSHED);
  assign bus.ar_wr_en  = bus.s_arvalid && bus.s_arready;

  // A new beat may be presented only in RUN with a queued AR and a free
  // credit; once presented, ar_pend keeps it up until it is accepted.
  assign credit_ok     = (outstanding < MAX_CNT);
  assign issue_ok      = (state == RUN) && !bus.ar_rd_empty && credit_ok;
  assign bus.m_arvalid = ar_pend || issue_ok;
  assign ar_hs         = bus.m_arvalid && bus.m_arready;
  assign bus.ar_rd_en  = ar_hs;

  // Responses are accepted downstream whenever the R FIFO has room.
  assign bus.m_rready  = !bus.r_wr_full;
  assign bus.r_wr_en   = bus.m_rvalid && bus.m_rready;

  // The R FIFO head is offered upstream as soon as it is non-empty.
  assign bus.s_rvalid  = !bus.r_rd_empty;
  assign r_pop         = bus.s_rvalid && bus.s_rready;
  assign bus.r_rd_en   = r_pop;

  // Flush sequencing: RUN -> DRAIN on request, DRAIN -> FLUSHED once nothing
  // is pending or in flight, back to RUN when the request drops.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= RUN;
      flush_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (flush_req) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!flush_req) begin
            state <= RUN;
          end else if ((outstanding == '0) && !ar_pend) begin
            state      <= FLUSHED;
            flush_done <= 1'b1;
          end
        end
        FLUSHED: begin
          if (!flush_req) begin
            state      <= RUN;
            flush_done <= 1'b0;
          end
        end
        default: begin
          state      <= RUN;
          flush_done <= 1'b0;
        end
      endcase
    end
  end

  // Remember a presented-but-unaccepted beat so m_arvalid cannot drop early.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ar_pend <= 1'b0;
    end else begin
      ar_pend <= bus.m_arvalid && !bus.m_arready;
    end
  end

  // In-flight count: up on AR handshake, down on upstream R pop, clamped at both ends.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else begin
      case ({ar_hs, r_pop})
        2'b10: begin
          if (outstanding != MAX_CNT) begin
            outstanding <= outstanding + 1'b1;
          end
        end
        2'b01: begin
          if (outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
          end
        end
        default: begin
          outstanding <= outstanding;
        end
      endcase
    end
  end

`ifdef AXI4_LITE_RD_FIFO_CTRL_TIMEOUT_EN
  localparam int            WW     = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_LIM = WW'(TIMEOUT);

  logic [WW-1:0] wd_cnt;

  // Watchdog: count idle cycles while reads are in flight; the flag is
  // raised on the edge where the count reaches TIMEOUT and then sticks.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (bus.r_wr_en || (outstanding == '0)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != TO_LIM) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == (TO_LIM - 1'b1)) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  // Watchdog absent in this build; the expression is constant 0.
  assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_axi4_lite_rd_fifo_ctrl.sv
// Directed bench for axi4_lite_rd_fifo_ctrl with MAX_OUT=4, TIMEOUT=16.
// The FIFO status flags are driven by hand; each step sets inputs shortly
// after a rising edge and checks outputs before the next one.
module tb_axi4_lite_rd_fifo_ctrl;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);
  localparam int TIMEOUT = 16;

  logic          aclk;
  logic          aresetn;
  logic          flush_req;
  logic          flush_done;
  logic [CW-1:0] outstanding;
  logic          timeout_err;

  int errors;
  int checks;
  int hs_cnt;
  int hs_base;

  axi4_lite_rd_fifo_ctrl_if dif ();

  axi4_lite_rd_fifo_ctrl #(
    .MAX_OUT (MAX_OUT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (dif),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .outstanding (outstanding),
    .timeout_err (timeout_err)
  );

  // Free-running 10-unit clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Count downstream AR handshakes.
  always @(posedge aclk) begin
    if (aresetn && dif.ar_rd_en) hs_cnt++;
  end

  // Popping a response with nothing in flight is a protocol error.
  always @(negedge aclk) begin
    if (aresetn && dif.r_rd_en && (outstanding == '0)) begin
      errors++;
      $error("[TB] FAIL underflow observed=r_rd_en_at_0 expected=no_pop");
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CW-1:0] obs, input int exp);
    logic [31:0] o;
    logic [31:0] e;
    o = 32'(obs);
    e = exp;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hs_cnt = 0;
    aresetn         = 1'b0;
    flush_req       = 1'b0;
    dif.s_arvalid   = 1'b0;
    dif.ar_wr_full  = 1'b0;
    dif.ar_rd_empty = 1'b1;
    dif.m_arready   = 1'b0;
    dif.m_rvalid    = 1'b0;
    dif.r_wr_full   = 1'b0;
    dif.r_rd_empty  = 1'b1;
    dif.s_rready    = 1'b0;

    // Reset state
    tick();
    check_cnt("rst_outstanding", outstanding, 0);
    check_bit("rst_m_arvalid", dif.m_arvalid, 1'b0);
    check_bit("rst_flush_done", flush_done, 1'b0);
    check_bit("rst_timeout_err", timeout_err, 1'b0);
    check_bit("rst_s_arready", dif.s_arready, 1'b1);
    aresetn = 1'b1;
    tick();

    // Single read
    dif.s_arvalid = 1'b1;
    #1;
    check_bit("single_s_arready", dif.s_arready, 1'b1);
    check_bit("single_ar_wr_en", dif.ar_wr_en, 1'b1);
    tick();
    dif.s_arvalid   = 1'b0;
    dif.ar_rd_empty = 1'b0;
    dif.m_arready   = 1'b1;
    #1;
    check_bit("single_m_arvalid", dif.m_arvalid, 1'b1);
    check_bit("single_ar_rd_en", dif.ar_rd_en, 1'b1);
    check_cnt("single_out0", outstanding, 0);
    tick();
    dif.ar_rd_empty = 1'b1;
    #1;
    check_bit("single_m_arvalid_low", dif.m_arvalid, 1'b0);
    check_cnt("single_out1", outstanding, 1);
    tick();
    tick();
    dif.m_rvalid = 1'b1;
    #1;
    check_bit("single_m_rready", dif.m_rready, 1'b1);
    check_bit("single_r_wr_en", dif.r_wr_en, 1'b1);
    tick();
    dif.m_rvalid   = 1'b0;
    dif.r_rd_empty = 1'b0;
    dif.s_rready   = 1'b1;
    #1;
    check_bit("single_s_rvalid", dif.s_rvalid, 1'b1);
    check_bit("single_r_rd_en", dif.r_rd_en, 1'b1);
    check_cnt("single_out_pre_pop", outstanding, 1);
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_bit("single_s_rvalid_low", dif.s_rvalid, 1'b0);
    check_cnt("single_out_end", outstanding, 0);

    // Credit stall: plenty of queued ARs, no responses popped
    hs_base = hs_cnt;
    dif.ar_rd_empty = 1'b0;
    #1;
    check_bit("credit_first_valid", dif.m_arvalid, 1'b1);
    repeat (4) tick();
    check_cnt("credit_out4", outstanding, 4);
    check_bit("credit_m_arvalid_low", dif.m_arvalid, 1'b0);
    check_bit("credit_ar_rd_en_low", dif.ar_rd_en, 1'b0);
    tick();
    check_cnt("credit_out4_hold", outstanding, 4);
    check_bit("credit_m_arvalid_hold", dif.m_arvalid, 1'b0);
    check_int("credit_hs4", hs_cnt - hs_base, 4);
    dif.r_rd_empty = 1'b0;
    #1;
    check_bit("credit_release_pop", dif.r_rd_en, 1'b1);
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("credit_out3", outstanding, 3);
    check_bit("credit_fifth_valid", dif.m_arvalid, 1'b1);
    tick();
    dif.ar_rd_empty = 1'b1;
    #1;
    check_cnt("credit_out4_again", outstanding, 4);
    check_int("credit_hs5", hs_cnt - hs_base, 5);
    dif.r_rd_empty = 1'b0;
    repeat (4) tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("credit_drained", outstanding, 0);

    // Simultaneous increment and decrement
    dif.ar_rd_empty = 1'b0;
    repeat (2) tick();
    check_cnt("simul_out2", outstanding, 2);
    dif.r_rd_empty = 1'b0;
    #1;
    check_bit("simul_ar_rd_en", dif.ar_rd_en, 1'b1);
    check_bit("simul_r_rd_en", dif.r_rd_en, 1'b1);
    tick();
    dif.ar_rd_empty = 1'b1;
    #1;
    check_cnt("simul_out_stays2", outstanding, 2);
    repeat (2) tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("simul_out0", outstanding, 0);

    // R FIFO backpressure
    dif.r_wr_full = 1'b1;
    dif.m_rvalid  = 1'b1;
    #1;
    check_bit("bp_m_rready_low", dif.m_rready, 1'b0);
    check_bit("bp_r_wr_en_low", dif.r_wr_en, 1'b0);
    tick();
    dif.r_wr_full = 1'b0;
    #1;
    check_bit("bp_m_rready_high", dif.m_rready, 1'b1);
    check_bit("bp_r_wr_en_high", dif.r_wr_en, 1'b1);
    tick();
    dif.m_rvalid = 1'b0;

    // AXI stability across a flush, then drain to FLUSHED and resume
    dif.m_arready   = 1'b0;
    dif.ar_rd_empty = 1'b0;
    #1;
    check_bit("stab_valid", dif.m_arvalid, 1'b1);
    check_bit("stab_no_pop", dif.ar_rd_en, 1'b0);
    tick();
    flush_req = 1'b1;
    #1;
    check_bit("stab_valid_pend", dif.m_arvalid, 1'b1);
    tick();
    check_bit("stab_valid_drain", dif.m_arvalid, 1'b1);
    check_bit("stab_flush_done0", flush_done, 1'b0);
    check_cnt("stab_out0", outstanding, 0);
    tick();
    dif.m_arready = 1'b1;
    #1;
    check_bit("stab_accept", dif.ar_rd_en, 1'b1);
    tick();
    check_bit("drain_no_issue", dif.m_arvalid, 1'b0);
    check_cnt("drain_out1", outstanding, 1);
    check_bit("drain_flush_done0", flush_done, 1'b0);
    dif.r_rd_empty = 1'b0;
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("drain_out0", outstanding, 0);
    check_bit("drain_flush_done_still0", flush_done, 1'b0);
    tick();
    check_bit("flushed_done", flush_done, 1'b1);
    check_bit("flushed_s_arready", dif.s_arready, 1'b0);
    check_bit("flushed_no_issue", dif.m_arvalid, 1'b0);
    flush_req = 1'b0;
    #1;
    check_bit("flushed_done_hold", flush_done, 1'b1);
    tick();
    check_bit("resume_done_clear", flush_done, 1'b0);
    check_bit("resume_s_arready", dif.s_arready, 1'b1);
    check_bit("resume_issue", dif.m_arvalid, 1'b1);
    tick();
    dif.ar_rd_empty = 1'b1;
    #1;
    check_cnt("resume_out1", outstanding, 1);
    dif.r_rd_empty = 1'b0;
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("resume_out0", outstanding, 0);

`ifdef AXI4_LITE_RD_FIFO_CTRL_TIMEOUT_EN
    // Watchdog fires exactly TIMEOUT cycles after the handshake and sticks
    dif.ar_rd_empty = 1'b0;
    #1;
    check_bit("to_issue", dif.ar_rd_en, 1'b1);
    tick();
    dif.ar_rd_empty = 1'b1;
    #1;
    check_bit("to_err_start", timeout_err, 1'b0);
    repeat (15) tick();
    check_bit("to_err_at15", timeout_err, 1'b0);
    tick();
    check_bit("to_err_at16", timeout_err, 1'b1);
    dif.m_rvalid = 1'b1;
    tick();
    dif.m_rvalid   = 1'b0;
    dif.r_rd_empty = 1'b0;
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("to_out0", outstanding, 0);
    check_bit("to_err_sticky", timeout_err, 1'b1);
`else
    // Without the watchdog a long-idle read never raises the flag
    dif.ar_rd_empty = 1'b0;
    tick();
    dif.ar_rd_empty = 1'b1;
    repeat (20) tick();
    check_cnt("nowd_out1", outstanding, 1);
    check_bit("nowd_err_low", timeout_err, 1'b0);
    dif.r_rd_empty = 1'b0;
    tick();
    dif.r_rd_empty = 1'b1;
    #1;
    check_cnt("nowd_out0", outstanding, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
